// File: rtl/bitcoin_pkg.sv
// Definitions shared by the bitcoin hash engine and its nonce_select back end:
// FSM state type, result record layout and the default nonce count.
package bitcoin_pkg;

    localparam int DEFAULT_NUM_NONCES = 16;

    localparam logic [15:0] RES_HASH_OFS  = 16'd0;
    localparam logic [15:0] RES_NONCE_OFS = 16'd1;
    localparam logic [15:0] RES_COUNT_OFS = 16'd2;
    localparam logic [15:0] RES_MASK_OFS  = 16'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_LAST     = 3'd2,
        ST_WR_HASH  = 3'd3,
        ST_WR_NONCE = 3'd4,
        ST_WR_COUNT = 3'd5,
        ST_WR_MASK  = 3'd6
    } nonce_sel_state_t;

    // Index width for a nonce count, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nonce_select_if.sv
// Start/done handshake, scan configuration, scan result and word-memory bus
// of nonce_select. The slave modport is the nonce_select side.
interface nonce_select_if
    import bitcoin_pkg::*;
#(
    parameter int IDX_W = idx_width(DEFAULT_NUM_NONCES)
);
    logic             start;
    logic [15:0]      hash_addr;
    logic [15:0]      result_addr;
    logic [31:0]      target;
    logic             done;
    logic             found;
    logic [IDX_W-1:0] best_nonce;
    logic [31:0]      best_hash;

    logic             mem_clk;
    logic             mem_we;
    logic [15:0]      mem_addr;
    logic [31:0]      mem_write_data;
    logic [31:0]      mem_read_data;

    modport master (
        output start, hash_addr, result_addr, target, mem_read_data,
        input  done, found, best_nonce, best_hash,
        input  mem_clk, mem_we, mem_addr, mem_write_data
    );

    modport slave (
        input  start, hash_addr, result_addr, target, mem_read_data,
        output done, found, best_nonce, best_hash,
        output mem_clk, mem_we, mem_addr, mem_write_data
    );

endinterface

// File: rtl/nonce_select_min_tracker.sv
// Running minimum / argmin / hit-count unit for nonce_select.
// With NONCE_SELECT_HIT_MASK_EN defined it also keeps a per-nonce hit bitmap.
module min_tracker
    import bitcoin_pkg::*;
#(
    parameter int IDX_W = idx_width(DEFAULT_NUM_NONCES)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             valid,
    input  logic [31:0]      value,
    input  logic [IDX_W-1:0] index,
    input  logic [31:0]      target,
    output logic [31:0]      min_q,
    output logic [IDX_W-1:0] idx_q,
    output logic [IDX_W:0]   cnt_q,
    output logic [31:0]      min_nxt
`ifdef NONCE_SELECT_HIT_MASK_EN
    ,
    output logic [31:0]      mask_q
`endif
);

    logic [IDX_W-1:0] idx_nxt;
    logic [IDX_W:0]   cnt_nxt;
`ifdef NONCE_SELECT_HIT_MASK_EN
    logic [31:0]      mask_nxt;
    logic [4:0]       mask_bit;
    assign mask_bit = 5'(index);
`endif

    // Index 0 always wins so an all-ones first hash is still selected.
    always_comb begin
        min_nxt = min_q;
        idx_nxt = idx_q;
        cnt_nxt = cnt_q;
`ifdef NONCE_SELECT_HIT_MASK_EN
        mask_nxt = mask_q;
`endif
        if (clear) begin
            min_nxt = '1;
            idx_nxt = '0;
            cnt_nxt = '0;
`ifdef NONCE_SELECT_HIT_MASK_EN
            mask_nxt = '0;
`endif
        end else if (valid) begin
            if ((value < min_q) || (index == '0)) begin
                min_nxt = value;
                idx_nxt = index;
            end
            if (value < target) begin
                cnt_nxt = cnt_q + 1'b1;
`ifdef NONCE_SELECT_HIT_MASK_EN
                mask_nxt[mask_bit] = 1'b1;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q  <= '0;
            idx_q  <= '0;
            cnt_q  <= '0;
`ifdef NONCE_SELECT_HIT_MASK_EN
            mask_q <= '0;
`endif
        end else begin
            min_q  <= min_nxt;
            idx_q  <= idx_nxt;
            cnt_q  <= cnt_nxt;
`ifdef NONCE_SELECT_HIT_MASK_EN
            mask_q <= mask_nxt;
`endif
        end
    end

endmodule

// File: rtl/nonce_select.sv
// Scans NUM_NONCES final-hash words, picks the smallest and writes a result
// record. Define NONCE_SELECT_HIT_MASK_EN to also write the hit bitmap.
module nonce_select
    import bitcoin_pkg::*;
#(
    parameter int NUM_NONCES = DEFAULT_NUM_NONCES,
    parameter int IDX_W      = idx_width(NUM_NONCES)
) (
    input  logic           clk,
    input  logic           reset_n,
    nonce_select_if.slave  bus
);

    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NUM_NONCES - 1);

    nonce_sel_state_t state_q, state_d;

    logic [IDX_W-1:0] k_q, k_d;
    logic [15:0]      hash_base_q;
    logic [15:0]      res_base_q;
    logic [31:0]      target_q;
    logic             accept;
    logic             clear;
    logic             load_best;

    logic             vld_p1;
    logic [IDX_W-1:0] idx_p1;

    logic             mem_we_q, mem_we_d;
    logic [15:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;

    logic             found_q;
    logic [IDX_W-1:0] best_nonce_q;
    logic [31:0]      best_hash_q;

    logic [31:0]      min_q, min_nxt;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W:0]   cnt_q;
`ifdef NONCE_SELECT_HIT_MASK_EN
    logic [31:0]      mask_q;
`endif

    assign accept = (state_q == ST_IDLE) && bus.start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (bus.start) state_d = ST_READ;
            ST_READ:     if (k_q == K_LAST) state_d = ST_LAST;
            ST_LAST:     state_d = ST_WR_HASH;
            ST_WR_HASH:  state_d = ST_WR_NONCE;
            ST_WR_NONCE: state_d = ST_WR_COUNT;
`ifdef NONCE_SELECT_HIT_MASK_EN
            ST_WR_COUNT: state_d = ST_WR_MASK;
`else
            ST_WR_COUNT: state_d = ST_IDLE;
`endif
            ST_WR_MASK:  state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Memory outputs are registered, so each state sets up the next cycle's bus.
    always_comb begin
        k_d         = k_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        clear       = 1'b0;
        load_best   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    clear      = 1'b1;
                    k_d        = '0;
                    mem_addr_d = bus.hash_addr;
                end
            end
            ST_READ: begin
                if (k_q != K_LAST) begin
                    k_d        = k_q + 1'b1;
                    mem_addr_d = hash_base_q + 16'(k_q) + 16'd1;
                end
            end
            ST_LAST: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = res_base_q + RES_HASH_OFS;
                mem_wdata_d = min_nxt;
            end
            ST_WR_HASH: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = res_base_q + RES_NONCE_OFS;
                mem_wdata_d = 32'(idx_q);
            end
            ST_WR_NONCE: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = res_base_q + RES_COUNT_OFS;
                mem_wdata_d = 32'(cnt_q);
            end
            ST_WR_COUNT: begin
`ifdef NONCE_SELECT_HIT_MASK_EN
                mem_we_d    = 1'b1;
                mem_addr_d  = res_base_q + RES_MASK_OFS;
                mem_wdata_d = mask_q;
`else
                load_best   = 1'b1;
`endif
            end
            ST_WR_MASK: load_best = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            k_q          <= '0;
            vld_p1       <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            found_q      <= 1'b0;
            best_nonce_q <= '0;
            best_hash_q  <= '0;
        end else begin
            k_q          <= k_d;
            vld_p1       <= (state_q == ST_READ);
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            if (load_best) begin
                found_q      <= (cnt_q != '0);
                best_nonce_q <= idx_q;
                best_hash_q  <= min_q;
            end
        end
    end

    // ---- p0 -> p1: read data returns one cycle after its address ----
    always_ff @(posedge clk) begin
        idx_p1 <= k_q;
        if (accept) begin
            hash_base_q <= bus.hash_addr;
            res_base_q  <= bus.result_addr;
            target_q    <= bus.target;
        end
    end

    min_tracker #(
        .IDX_W (IDX_W)
    ) u_min_tracker (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .valid   (vld_p1),
        .value   (bus.mem_read_data),
        .index   (idx_p1),
        .target  (target_q),
        .min_q   (min_q),
        .idx_q   (idx_q),
        .cnt_q   (cnt_q),
        .min_nxt (min_nxt)
`ifdef NONCE_SELECT_HIT_MASK_EN
        ,
        .mask_q  (mask_q)
`endif
    );

    assign bus.done           = (state_q == ST_IDLE);
    assign bus.mem_clk        = clk;
    assign bus.mem_we         = mem_we_q;
    assign bus.mem_addr       = mem_addr_q;
    assign bus.mem_write_data = mem_wdata_q;
    assign bus.found          = found_q;
    assign bus.best_nonce     = best_nonce_q;
    assign bus.best_hash      = best_hash_q;

endmodule

// File: tb/tb_nonce_select.sv
// Scoreboard bench for nonce_select: expected writes and scan results are
// queued at start time and popped by a negedge monitor.
module tb_nonce_select;

    localparam int N     = bitcoin_pkg::DEFAULT_NUM_NONCES;
    localparam int IDX_W = bitcoin_pkg::idx_width(N);
`ifdef NONCE_SELECT_HIT_MASK_EN
    localparam int BUSY = N + 5;
`else
    localparam int BUSY = N + 4;
`endif

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic             found;
        logic [IDX_W-1:0] nonce;
        logic [31:0]      hash;
        int               busy;
    } res_t;

    logic clk = 1'b0;
    logic reset_n;

    nonce_select_if #(.IDX_W(IDX_W)) bus ();

    nonce_select #(
        .NUM_NONCES (N)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] hmem [0:65535];
    logic [31:0] vals [N];

    always @(posedge clk) bus.mem_read_data <= hmem[bus.mem_addr];

    wr_t  exp_wr_q  [$];
    res_t exp_res_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: argmin with lowest index on ties, hits are strictly below target.
    task automatic push_expect(input logic [15:0] ra, input logic [31:0] tg);
        logic [31:0] mn;
        int          mi;
        int          cnt;
        logic [31:0] mask;
        res_t        r;
        mn = vals[0]; mi = 0; cnt = 0; mask = '0;
        for (int i = 0; i < N; i++) begin
            if (vals[i] < mn) begin
                mn = vals[i];
                mi = i;
            end
            if (vals[i] < tg) begin
                cnt++;
                mask[i] = 1'b1;
            end
        end
        exp_wr_q.push_back('{addr: ra + 16'd0, data: mn});
        exp_wr_q.push_back('{addr: ra + 16'd1, data: 32'(mi)});
        exp_wr_q.push_back('{addr: ra + 16'd2, data: 32'(cnt)});
`ifdef NONCE_SELECT_HIT_MASK_EN
        exp_wr_q.push_back('{addr: ra + 16'd3, data: mask});
`endif
        r.found = (cnt != 0);
        r.nonce = IDX_W'(mi);
        r.hash  = mn;
        r.busy  = BUSY;
        exp_res_q.push_back(r);
    endtask

    task automatic monitor_loop();
        logic done_prev;
        int   busy;
        wr_t  w;
        res_t r;
        done_prev = bus.done;
        busy = 0;
        forever begin
            @(negedge clk);
            if (bus.mem_we) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write addr=%0h data=%0h required=none",
                             bus.mem_addr, bus.mem_write_data);
                end else begin
                    w = exp_wr_q.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(w.addr));
                    check("wr_data", bus.mem_write_data, w.data);
                end
            end
            if (!bus.done && done_prev) busy = 1;
            else if (!bus.done)         busy++;
            if (bus.done && !done_prev) begin
                if (exp_res_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    r = exp_res_q.pop_front();
                    check("found", 32'(bus.found), 32'(r.found));
                    check("best_nonce", 32'(bus.best_nonce), 32'(r.nonce));
                    check("best_hash", bus.best_hash, r.hash);
                    if (r.busy >= 0) check("busy_cycles", 32'(busy), 32'(r.busy));
                end
            end
            done_prev = bus.done;
        end
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (!bus.done && c < 200) begin
            @(posedge clk);
            #1;
            c++;
        end
        check("done_reached", 32'(bus.done), 32'd1);
    endtask

    task automatic load_hashes(input logic [15:0] ha);
        for (int i = 0; i < N; i++) hmem[16'(ha + 16'(i))] = vals[i];
    endtask

    task automatic issue_start(input logic [15:0] ha, input logic [15:0] ra, input logic [31:0] tg);
        bus.hash_addr   = ha;
        bus.result_addr = ra;
        bus.target      = tg;
        bus.start       = 1'b1;
        @(posedge clk);
        #1;
        bus.start       = 1'b0;
        bus.hash_addr   = 16'($urandom);
        bus.result_addr = 16'($urandom);
        bus.target      = $urandom;
    endtask

    task automatic run_scan(input logic [15:0] ha, input logic [15:0] ra,
                            input logic [31:0] tg, input bit pulse);
        load_hashes(ha);
        push_expect(ra, tg);
        issue_start(ha, ra, tg);
        if (pulse) begin
            repeat (N + 1) @(posedge clk);
            #1;
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        wait_idle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        res_t        rr;
        logic [31:0] tg;
        reset_n         = 1'b0;
        bus.start       = 1'b0;
        bus.hash_addr   = '0;
        bus.result_addr = '0;
        bus.target      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(bus.done), 32'd1);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_wdata", bus.mem_write_data, 32'd0);
        check("rst_found", 32'(bus.found), 32'd0);
        check("rst_best_nonce", 32'(bus.best_nonce), 32'd0);
        check("rst_best_hash", bus.best_hash, 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        fork
            monitor_loop();
        join_none

        for (int i = 0; i < N; i++) vals[i] = 32'(100 + i);
        run_scan(16'h1000, 16'h2000, 32'h0, 1'b0);

        for (int i = 0; i < N; i++) vals[i] = 32'(500 - i);
        run_scan(16'h1000, 16'h2000, 32'd495, 1'b0);

        for (int i = 0; i < N; i++) vals[i] = 32'(100 + i);
        vals[3] = 32'd7;
        vals[9] = 32'd7;
        run_scan(16'h1000, 16'h2000, 32'd8, 1'b0);

        // Abort at READ k=5: no writes, outputs return to their reset values.
        for (int i = 0; i < N; i++) vals[i] = 32'(3 + i);
        load_hashes(16'h1000);
        rr.found = 1'b0;
        rr.nonce = '0;
        rr.hash  = '0;
        rr.busy  = -1;
        exp_res_q.push_back(rr);
        issue_start(16'h1000, 16'h2000, 32'd50);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("abort_done", 32'(bus.done), 32'd1);
        check("abort_mem_we", 32'(bus.mem_we), 32'd0);
        check("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("abort_mem_wdata", bus.mem_write_data, 32'd0);
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < N; i++) vals[i] = 32'((i * 37 + 11) % 64 + 20);
        run_scan(16'hFFF8, 16'h3000, 32'd60, 1'b1);

        for (int i = 0; i < N; i++) vals[i] = 32'hFFFF_FFFF;
        run_scan(16'h1000, 16'h2000, 32'hFFFF_FFFF, 1'b0);

        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < N; i++)
                vals[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            case ($urandom_range(0, 3))
                0:       tg = 32'h0;
                1:       tg = 32'hFFFF_FFFF;
                2:       tg = 32'($urandom_range(0, 16));
                default: tg = $urandom;
            endcase
            run_scan(16'($urandom), 16'($urandom_range(0, 16'hFFF0)), tg, 1'($urandom_range(0, 1)));
        end

        repeat (4) @(posedge clk);
        #1;
        check("writes_left", 32'(exp_wr_q.size()), 32'd0);
        check("results_left", 32'(exp_res_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
